// File: rtl/nes_controller_ports.sv
// nes_controller_ports: NES $4016/$4017 serial controller ports with optional Four Score chaining.
module nes_controller_ports #(
    parameter int   CHANNELS   = 2,
    parameter int   FOUR_SCORE = 0,
    parameter logic FILL       = 1'b1,
    localparam int  PADS       = (FOUR_SCORE != 0) ? 4 : CHANNELS,
    localparam int  LEN        = (FOUR_SCORE != 0) ? 24 : 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PADS*8-1:0]     buttons,
    input  logic                  buttons_update,
    input  logic                  strobe,
    input  logic [CHANNELS-1:0]   shift,
    output logic [CHANNELS*8-1:0] reg_out,
    output logic [CHANNELS-1:0]   exhausted
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(LEN);

    logic [PADS*8-1:0]   shadow;
    logic [CHANNELS-1:0] shift_prev;

    always_ff @(posedge clock) begin
        shadow     <= reset ? '0 : buttons_update ? buttons : shadow;
        shift_prev <= reset ? '0 : shift;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [LEN-1:0] image;
        logic [LEN-1:0] sr;
        logic [CW-1:0]  cnt;
        logic           rise;
        logic           bit_out;

        // Four Score appends the second pad on this port, then a port signature byte
        if (FOUR_SCORE != 0) begin : g_fs
            assign image = {(c == 0) ? 8'h10 : 8'h20, shadow[(c+2)*8 +: 8], shadow[c*8 +: 8]};
        end else begin : g_std
            assign image = shadow[c*8 +: 8];
        end

        assign rise = shift[c] & ~shift_prev[c];

        always_ff @(posedge clock) begin
            if (reset) begin
                sr  <= '0;
                cnt <= FULL;
            end else if (strobe) begin
                sr  <= image;
                cnt <= '0;
            end else if (rise && cnt != FULL) begin
                sr  <= {FILL, sr[LEN-1:1]};
                cnt <= cnt + 1'b1;
            end
        end

        assign bit_out             = (cnt == FULL) ? FILL : sr[0];
        assign reg_out[c*8 +: 8]   = {7'b0100000, bit_out};
        assign exhausted[c]        = cnt == FULL;
    end
endmodule

// File: tb/tb_nes_controller_ports.sv
// tb_nes_controller_ports: directed checks of a default two-port instance and a Four Score instance.
module tb_nes_controller_ports;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] buttons = '0;
    logic [31:0] fs_buttons = '0;
    logic        buttons_update = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  shift = '0;
    logic [15:0] reg_out;
    logic [1:0]  exhausted;
    logic [15:0] fs_reg_out;
    logic [1:0]  fs_exhausted;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    nes_controller_ports dut (
        .clock(clock), .reset(reset), .buttons(buttons), .buttons_update(buttons_update),
        .strobe(strobe), .shift(shift), .reg_out(reg_out), .exhausted(exhausted)
    );

    nes_controller_ports #(.CHANNELS(2), .FOUR_SCORE(1)) dut_fs (
        .clock(clock), .reset(reset), .buttons(fs_buttons), .buttons_update(buttons_update),
        .strobe(strobe), .shift(shift), .reg_out(fs_reg_out), .exhausted(fs_exhausted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m);
        shift = m;
        tick();
        shift = '0;
        tick();
    endtask

    task automatic load;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0]  pat;
        logic [23:0] img0;
        logic [23:0] img1;
        tick();
        tick();
        check("reset_reg_out", reg_out, 16'h4141);
        check("reset_exhausted", exhausted, 2'b11);
        check("reset_fs_reg_out", fs_reg_out, 16'h4141);
        check("reset_fs_exhausted", fs_exhausted, 2'b11);
        reset = 1'b0;

        // basic read of 8'b1000_1001 on port 0
        pat = 8'b1000_1001;
        buttons = {8'h00, pat};
        buttons_update = 1'b1;
        tick();
        buttons_update = 1'b0;
        load();
        check("loaded_exhausted", exhausted, 2'b00);
        for (int i = 0; i < 10; i++) begin
            shift = 2'b01;
            #1;
            check($sformatf("read%0d", i), reg_out[7:0], (i < 8) ? {7'b0100000, pat[i]} : 8'h41);
            tick();
            shift = '0;
            tick();
            if (i == 7) check("exhausted_after_8", exhausted, 2'b01);
        end

        // long read: held shift yields one shift only
        load();
        shift = 2'b01;
        repeat (5) tick();
        shift = '0;
        tick();
        check("long_read_bit1", reg_out, 16'h4040);
        check("long_read_port1_exh", exhausted, 2'b00);
        pulse(2'b01);
        check("after_long_bit2", reg_out[7:0], 8'h40);
        pulse(2'b01);
        check("after_long_bit3", reg_out[7:0], 8'h41);

        // strobe held high: every read is A
        strobe = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse(2'b01);
            check($sformatf("strobe_high_read%0d", i), reg_out[7:0], 8'h41);
        end
        strobe = 1'b0;
        tick();
        check("restart_A", reg_out[7:0], 8'h41);
        pulse(2'b01);
        check("restart_B", reg_out[7:0], 8'h40);

        // update latency: same-cycle load uses the old shadow
        buttons = 16'h0000;
        buttons_update = 1'b1;
        tick();
        buttons_update = 1'b0;
        load();
        check("old_A_zero", reg_out[7:0], 8'h40);
        buttons = 16'h0001;
        buttons_update = 1'b1;
        strobe = 1'b1;
        tick();
        buttons_update = 1'b0;
        check("latency_old", reg_out[7:0], 8'h40);
        tick();
        check("latency_new", reg_out[7:0], 8'h41);
        strobe = 1'b0;
        tick();

        // independent ports
        buttons = 16'hAA55;
        buttons_update = 1'b1;
        tick();
        buttons_update = 1'b0;
        load();
        check("indep_initial", reg_out, 16'h4041);
        pulse(2'b11);
        check("indep_both", reg_out, 16'h4140);
        pulse(2'b10);
        check("indep_port1_only", reg_out, 16'h4040);

        // reset beats strobe, shift and update mid-report
        pulse(2'b01);
        buttons = 16'hFFFF;
        reset = 1'b1;
        strobe = 1'b1;
        buttons_update = 1'b1;
        shift = 2'b11;
        tick();
        reset = 1'b0;
        strobe = 1'b0;
        buttons_update = 1'b0;
        shift = '0;
        check("mid_reset_reg_out", reg_out, 16'h4141);
        check("mid_reset_exhausted", exhausted, 2'b11);
        tick();
        load();
        check("shadow_cleared", reg_out, 16'h4040);

        // Four Score chaining
        fs_buttons = {8'h08, 8'h04, 8'h02, 8'h01};
        buttons_update = 1'b1;
        tick();
        buttons_update = 1'b0;
        load();
        img0 = 24'h100401;
        img1 = 24'h200802;
        for (int i = 0; i < 26; i++) begin
            shift = 2'b11;
            #1;
            check($sformatf("fs_read%0d", i), fs_reg_out,
                  {7'b0100000, (i < 24) ? img1[i] : 1'b1, 7'b0100000, (i < 24) ? img0[i] : 1'b1});
            tick();
            shift = '0;
            tick();
        end
        check("fs_exhausted", fs_exhausted, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nes_controller_ports.md
NES_CONTROLLER_PORTS -- requirements
Module: nes_controller_ports

Interface
REQ-001 Parameter CHANNELS, default 2, number of serial controller ports; legal range 1-4.
REQ-002 Parameter FOUR_SCORE, default 0; 1 selects 24-bit Four Score chaining; legal only with CHANNELS=2.
REQ-003 Parameter FILL, default 1'b1, the bit returned after a port's report is exhausted.
REQ-004 Derived PADS = FOUR_SCORE ? 4 : CHANNELS; LEN = FOUR_SCORE ? 24 : 8.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 buttons  input  PADS x 8  per-pad state, active-high; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
REQ-008 buttons_update  input  1  one-cycle pulse; captures buttons into the shadow register.
REQ-009 strobe  input  1  level; CPU $4016 write bit0.
REQ-010 shift  input  CHANNELS  per-port read level (CPU read of $4016+ch); may stay high for several cycles.
REQ-011 reg_out  output  CHANNELS x 8  per-port read byte = {3'b010, 4'b0000, serial bit}, i.e. 0x40 | bit.
REQ-012 exhausted  output  CHANNELS  high when the port has shifted LEN or more times since the last load.

Function
REQ-013 Shadow: on a buttons_update cycle, the shadow register SHALL capture buttons; otherwise it holds.
REQ-014 Load image per port ch SHALL be LEN bits, LSB-first: FOUR_SCORE=0 -> shadow[ch]; FOUR_SCORE=1 -> {signature, shadow[ch+2], shadow[ch]}, where signature = 8'h10 for ch0 and 8'h20 for ch1 (read order bit0 first).
REQ-015 Strobe high: every cycle, each port's shift register SHALL reload the load image and its count SHALL clear to 0; shift edges are ignored.
REQ-016 Shift edge: a port SHALL shift exactly once per rising edge of its shift bit (registered previous value compared), regardless of pulse length.
REQ-017 Shift operation while strobe low: register shifts right by one, FILL enters at MSB, count increments saturating at LEN.
REQ-018 Serial bit SHALL be register bit0 while count < LEN, and FILL once count = LEN.
REQ-019 reg_out SHALL be combinational from registered state (no input-to-output combinational path); a read sees the bit present before its own shift edge takes effect.
REQ-020 Shadow captured at edge N SHALL be visible in the load image from edge N+1 (one-cycle latency); a load on edge N uses the old shadow.
REQ-021 Simultaneous strobe high and shift edge: load wins, count = 0, the edge is consumed (not deferred).
REQ-022 Shift edge on a port with count = LEN: register and count hold; output stays FILL.
REQ-023 Ports SHALL operate independently; simultaneous shift edges on several ports each shift their own port only.
REQ-024 Strobe falling edge SHALL cause no extra action; the last reload image is retained.

Reset
REQ-025 On reset: shadow = 0, all shift registers = 0, count = LEN (exhausted), shift-edge history = 0.
REQ-026 Hence after reset reg_out[ch] = 0x40 | FILL (0x41 with default FILL) and exhausted = all ones.
REQ-027 Reset SHALL take priority over strobe, shift and buttons_update in the same cycle, including mid-report.

Verification
REQ-028 Basic read, defaults: buttons[0]=8'b1000_1001, update, strobe 1 then 0, 8 shift edges on port 0 -> reg_out[0] bits 1,0,0,1,0,0,0,1; 9th and 10th reads 0x41; exhausted[0]=1 after 8th edge.
REQ-029 Long read: shift[0] held high 5 cycles -> exactly one shift; port 1 state unchanged.
REQ-030 Strobe held high with 3 shift edges -> every read returns A bit; after strobe low, sequence restarts at A.
REQ-031 Update latency: buttons_update and strobe high on same cycle with new A=1, old A=0 -> reg_out[0]=0x40 that cycle's load, 0x41 after the next load cycle.
REQ-032 FOUR_SCORE=1: pads 0..3 = 01,02,04,08 -> port0 24 reads: A-bit 1 at read 0, bit 1 of pad2 at read 10, signature 1 at read 20, then FILL; port1: read 1, read 11, read 21 high.
REQ-033 Reset asserted after 3 shifts -> next cycle reg_out = 0x41 on all ports, exhausted all ones, shadow cleared.
